// File: rtl/fft_frame_ctrl.sv
// Ping-pong frame collector in front of the FFT/analyze pair: fills 16-sample
// frames, launches one at a time with a start/ready handshake, and returns the peak bin.
module fft_frame_ctrl #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             fft_start,
  input  logic             fft_ready,
  output logic [16*DW-1:0] frame_data,
  input  logic             ana_done,
  input  logic [3:0]       ana_freq,
  output logic             freq_valid,
  output logic [3:0]       freq_out,
  output logic [CW-1:0]    frame_cnt,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_RES} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem_q [2][16];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [3:0]    wr_idx_q, wr_idx_d;
  logic          overflow_q, overflow_d;
  logic          freq_valid_q, freq_valid_d;
  logic [3:0]    freq_q, freq_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic handshake, release_wr, write_ok, wr_en;

  assign handshake  = (state_q == LAUNCH) & fft_ready;
  // A bank released by this cycle's launch may be refilled in the same cycle.
  assign release_wr = handshake & (rd_bank_q == wr_bank_q);
  assign write_ok   = !full_q[wr_bank_q] | release_wr;
  assign wr_en      = in_valid & write_ok;

  assign in_ready   = write_ok;
  assign fft_start  = (state_q == LAUNCH);
  assign freq_valid = freq_valid_q;
  assign freq_out   = freq_q;
  assign frame_cnt  = cnt_q;
  assign overflow   = overflow_q;

  always_comb begin
    frame_data = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      frame_data[k*DW +: DW] = mem_q[rd_bank_q][k];
    end
  end

  always_comb begin
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    wr_idx_d     = wr_idx_q;
    overflow_d   = overflow_q;
    rd_bank_d    = rd_bank_q;
    state_d      = state_q;
    freq_valid_d = 1'b0;
    freq_d       = freq_q;
    cnt_d        = cnt_q;

    if (handshake) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    // Applied after the release so a same-cycle set of the same flag wins.
    if (wr_en) begin
      wr_idx_d = wr_idx_q + 4'd1;
      if (wr_idx_q == 4'd15) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (in_valid && !write_ok) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      IDLE:     if (full_q[rd_bank_q]) state_d = LAUNCH;
      LAUNCH:   if (handshake) state_d = WAIT_RES;
      WAIT_RES: begin
        if (ana_done) begin
          freq_d       = ana_freq;
          freq_valid_d = 1'b1;
          cnt_d        = cnt_q + CW'(1);
          state_d      = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      overflow_q   <= 1'b0;
      freq_valid_q <= 1'b0;
      freq_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_idx_q     <= wr_idx_d;
      overflow_q   <= overflow_d;
      freq_valid_q <= freq_valid_d;
      freq_q       <= freq_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_idx_q] <= in_data;
    end
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame controller in front of the FFT/analyze datapath. It collects serial input samples into 16-sample frames using ping-pong buffers and launches one frame at a time into the FFT engine with a start/ready handshake. It then waits for the analyzer's done pulse and returns the registered peak-bin index tagged with a frame count. It sits between the sample source and the FFT + analyze pair and is the only block that sequences them.

## Interface
- DW, 16, sample width in bits (real-valued input, two's complement)
- CW, 8, width of frame_cnt
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input sample present this cycle
- in_data  in  DW  input sample
- in_ready  out  1  current write bank can accept a sample this cycle (combinational)
- fft_start  out  1  frame offered to FFT engine (registered, Moore)
- fft_ready  in  1  FFT engine accepts frame; handshake = fft_start & fft_ready
- frame_data  out  16*DW  frame in the read bank; sample k at bits [k*DW +: DW], sample 0 = first received
- ana_done  in  1  analyzer finished current frame (1-cycle pulse)
- ana_freq  in  4  peak bin from analyzer, valid with ana_done
- freq_valid  out  1  1-cycle pulse: freq_out/frame_cnt valid
- freq_out  out  4  registered peak bin
- frame_cnt  out  CW  number of completed frames, wraps modulo 2^CW
- overflow  out  1  sticky: a sample was dropped

## Operation
- Storage: two banks of 16×DW; full[1:0] flags; wr_bank, wr_idx[3:0]; rd_bank.
- Write side: write_ok = !full[wr_bank] | release_wr, where release_wr = handshake this cycle on bank wr_bank. in_ready = write_ok.
- in_valid & write_ok: store at bank[wr_bank][wr_idx], then wr_idx+1. At wr_idx==15: set full[wr_bank], toggle wr_bank, and wr_idx wraps to 0.
- in_valid & !write_ok: drop the sample; overflow<=1 (sticky until rst); pointers are unchanged.
- Dispatch FSM with 3 states:
  - IDLE: if full[rd_bank], go to LAUNCH.
  - LAUNCH: fft_start=1; frame_data = bank[rd_bank]. On handshake: clear full[rd_bank], toggle rd_bank, go to WAIT_RES.
  - WAIT_RES: on ana_done, freq_out<=ana_freq, freq_valid<=1, frame_cnt<=frame_cnt+1, go to IDLE.
- Only one frame is in flight; no new launch until ana_done.
- ana_done outside WAIT_RES is ignored. fft_ready outside LAUNCH is ignored.
- frame_data outside LAUNCH: drives bank[rd_bank] (don't-care for the engine).
- Simultaneous events:
  - Release and set of the same bank flag in one cycle: set wins (the new frame is full). This is only possible via the release_wr path.
  - A write and a launch on different banks proceed independently.
- Reset mid-operation: all state is cleared and any in-flight frame is discarded. Bank contents need no reset.

## Timing
- Reset values: fft_start=0, freq_valid=0, freq_out=0, frame_cnt=0, overflow=0, in_ready=1, state=IDLE, full=0, wr_bank=rd_bank=0, wr_idx=0.
- 16th sample of a frame accepted in cycle k: full set at end of k; IDLE→LAUNCH at end of k+1; fft_start=1 from cycle k+2.
- fft_start stays high until the handshake; it drops the cycle after the handshake.
- ana_done in cycle j: freq_valid=1 and the new freq_out/frame_cnt appear in cycle j+1, for exactly one cycle of freq_valid.
- Earliest next fft_start after ana_done in cycle j: cycle j+2, if the other bank is full.
- Throughput: a sustained in_valid=1 stream never overflows if each frame's launch-to-ana_done span is ≤ 14 cycles with fft_ready=1.

## Test plan
- Reset, then 16 samples 0..15 on consecutive cycles, fft_ready=1 → fft_start high exactly in cycle k+2 after the 16th sample; frame_data slice k = k; handshake in the same cycle.
- Then ana_done with ana_freq=5 five cycles after the handshake → next cycle freq_valid=1, freq_out=5, frame_cnt=1; freq_valid low the cycle after.
- Hold fft_ready=0 and stream 48 samples → first 32 accepted; in_ready=0 afterwards; samples 33+ dropped; overflow=1 and stays 1. Then fft_ready=1 → frame 0 launches; bank 0 data = samples 0..15.
- Both banks full and the write pointer at bank 0, with the handshake on bank 0 in the same cycle as in_valid → in_ready=1 that cycle, sample accepted, overflow stays 0.
- ana_done pulsed in IDLE and in LAUNCH → no freq_valid, frame_cnt unchanged.
- Assert rst during WAIT_RES with 8 samples in the write bank → all outputs at reset values next cycle; a following ana_done is ignored; the next 16 samples form frame 0 from sample index 0.
